phase_sequencer: RTL

- Parametrised successor to the fixed 6-phase ring timer that drives the MiniBit controller.
- Generates a one-hot phase vector f[PHASES-1:0] that steps the controller through each instruction.
- Adds:
  - configurable phase count
  - halt/resume handshake as an explicit state machine
  - stall hold
  - early instruction termination
  - retired-instruction counter
  - instruction-start strobe
- Sits between the clock source and the controller decode logic; f replaces the old timer output one-for-one.

---
 rtl/phase_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   One-hot phase generator for the MiniBit controller. Steps through PHASES
//   phases per instruction and supports halt/resume, stall hold, synchronous
//   phase clear, output jamming, an instruction-start strobe and a count of
//   retired instructions.
//
//   Optional feature (macro PHASE_SEQ_SKIP_EN):
//     defined   - last_phase ends the current instruction early (wrap to 0).
//     undefined - last_phase is ignored; every instruction is PHASES long.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   rst_n        synchronous reset, active-low
//   timer_clear  synchronous clear of phase position (instr_count kept)
//   jam_f        forces f to zero; internal state unaffected
//   hlt          halt request
//   rx           resume strobe
//   stall        hold current phase
//   last_phase   current phase is the final one (skip feature only)
//   f            one-hot phase vector, masked by jam_f
//   phase_idx    binary index of current phase
//   instr_start  phase 0, running, not jammed
//   halted       high while halted
//   instr_count  retired-instruction counter (wraps)
module phase_sequencer #(
  parameter int unsigned PHASES = 6,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timer_clear,
  input  logic              jam_f,
  input  logic              hlt,
  input  logic              rx,
  input  logic              stall,
  input  logic              last_phase,
  output logic [PHASES-1:0] f,
  output logic [IDX_W-1:0]  phase_idx,
  output logic              instr_start,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               end_now;
  logic               advance;
  logic               wrap;

`ifdef PHASE_SEQ_SKIP_EN
  assign end_now = last_phase;
`else
  logic unused_last_phase;
  assign unused_last_phase = last_phase;
  assign end_now = 1'b0;
`endif

  assign wrap = (phase_q == IDX_W'(PHASES - 1)) || end_now;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    advance = 1'b0;

    if (timer_clear) begin
      // Clear also drops any pending halt.
      state_d = S_RUN;
      phase_d = '0;
    end else if (state_q == S_HALT) begin
      // Resume takes one phase step on the same edge; stall is not consulted.
      if (rx) begin
        state_d = S_RUN;
        advance = 1'b1;
      end
    end else if (hlt && !rx) begin
      state_d = S_HALT;
    end else if (!stall) begin
      advance = 1'b1;
    end

    if (advance) begin
      if (wrap) begin
        phase_d = '0;
        count_d = count_q + CNT_W'(1);
      end else begin
        phase_d = phase_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    f = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      f[i] = (phase_q == IDX_W'(i)) && !jam_f;
    end
  end

  assign phase_idx   = phase_q;
  assign halted      = (state_q == S_HALT);
  assign instr_start = (phase_q == '0) && (state_q == S_RUN) && !jam_f;
  assign instr_count = count_q;

endmodule
